calc_bcd_n: RTL and testbench

Parametrised decimal four-function calculator core. It replaces status polling with a valid/ready command handshake, supports NDIG-digit operands, and adds sequential multiply and divide, a negative-result flag and overflow detection. After every value change it converts the value to BCD and scans it out one digit per cycle to the display driver. It sits between the keypad command decoder and the multiplexed 7-segment display block.

---
 rtl/calc_bcd_n.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_calc_bcd_n.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_bcd_n.sv
// Decimal four-function calculator core: keypad commands in over valid/ready,
// sequential mul/div, double-dabble to BCD and a one-digit-per-cycle display scan.
module calc_bcd_n #(
    parameter int NDIG = 8,
    parameter int W    = 27,
    parameter int PW   = $clog2(NDIG)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cmd_valid,
    input  logic [3:0]    cmd,
    output logic          cmd_ready,
    output logic [1:0]    status,
    output logic [W-1:0]  value,
    output logic          neg,
    output logic [3:0]    data,
    output logic [PW-1:0] pos,
    output logic          data_valid
);

    localparam int CW   = $clog2(NDIG + 1);
    localparam int CNTW = $clog2(W);
    localparam int BW   = 4 * NDIG;
    localparam logic [2*W-1:0] MAX_VAL = (2*W)'(10**NDIG - 1);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [2:0] {ENT_A, ENT_B, MUL, DIV, CONV, SCAN, ERR} state_t;

    state_t            state_q, state_d;
    logic              ret_b_q, ret_b_d;
    logic [W-1:0]      value_q, value_d;
    logic              neg_q, neg_d;
    logic              fresh_q, fresh_d;
    logic [CW-1:0]     count_q, count_d;
    logic [W-1:0]      reg_a_q, reg_a_d;
    logic [W-1:0]      reg_b_q, reg_b_d;
    logic [1:0]        op_q, op_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [W-1:0]      sh_q, sh_d;
    logic [CNTW-1:0]   cyc_q, cyc_d;
    logic [2*W-1:0]    prod_q, prod_d;
    logic [2*W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]      rem_q, rem_d;
    logic [PW-1:0]     scan_q, scan_d;

    logic              accept;
    logic              start_conv;
    logic [W-1:0]      v10;
    logic [2*W-1:0]    sum;
    logic [2*W-1:0]    prod_n;
    logic [W:0]        div_tmp;
    logic [W:0]        div_diff;
    logic              q_bit;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     bcd_n;

    function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < NDIG; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Number of significant decimal digits; drives the entry digit limit.
    function automatic logic [CW-1:0] sig_digits(input logic [BW-1:0] b);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (b[4*i +: 4] != 4'd0) n = CW'(i + 1);
        end
        return n;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ENT_A;
            ret_b_q <= 1'b0;
            value_q <= '0;
            neg_q   <= 1'b0;
            fresh_q <= 1'b0;
            count_q <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
            op_q    <= '0;
            bcd_q   <= '0;
            sh_q    <= '0;
            cyc_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            scan_q  <= '0;
        end else begin
            state_q <= state_d;
            ret_b_q <= ret_b_d;
            value_q <= value_d;
            neg_q   <= neg_d;
            fresh_q <= fresh_d;
            count_q <= count_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            op_q    <= op_d;
            bcd_q   <= bcd_d;
            sh_q    <= sh_d;
            cyc_q   <= cyc_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            scan_q  <= scan_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_b_d    = ret_b_q;
        value_d    = value_q;
        neg_d      = neg_q;
        fresh_d    = fresh_q;
        count_d    = count_q;
        reg_a_d    = reg_a_q;
        reg_b_d    = reg_b_q;
        op_d       = op_q;
        bcd_d      = bcd_q;
        sh_d       = sh_q;
        cyc_d      = cyc_q;
        prod_d     = prod_q;
        mcand_d    = mcand_q;
        rem_d      = rem_q;
        scan_d     = scan_q;
        accept     = cmd_valid && (state_q == ENT_A || state_q == ENT_B);
        start_conv = 1'b0;
        v10        = value_q * W'(10) + W'(cmd);
        sum        = (2*W)'(reg_a_q) + (2*W)'(value_q);
        prod_n     = reg_b_q[0] ? prod_q + mcand_q : prod_q;
        div_tmp    = {rem_q, sh_q[W-1]};
        div_diff   = div_tmp - {1'b0, reg_b_q};
        q_bit      = (div_tmp >= {1'b0, reg_b_q});
        bcd_adj    = dd_adjust(bcd_q);
        bcd_n      = {bcd_adj[BW-2:0], sh_q[W-1]};

        case (state_q)
            ENT_A, ENT_B: begin
                if (accept) begin
                    if (cmd < 4'd10) begin
                        ret_b_d = (state_q == ENT_B);
                        if (fresh_q) begin
                            value_d    = W'(cmd);
                            neg_d      = 1'b0;
                            fresh_d    = 1'b0;
                            start_conv = 1'b1;
                        end else if (count_q < CW'(NDIG) && v10 != value_q) begin
                            value_d    = v10;
                            start_conv = 1'b1;
                        end
                    end else if (cmd == 4'b1111) begin
                        ret_b_d = (state_q == ENT_B);
                        fresh_d = 1'b0;
                        if (value_q != '0) begin
                            value_d    = value_q / W'(10);
                            neg_d      = 1'b0;
                            start_conv = 1'b1;
                        end
                    end else if (cmd == 4'b1110) begin
                        if (state_q == ENT_B) begin
                            reg_b_d = value_q;
                            cyc_d   = '0;
                            case (op_q)
                                OP_ADD: begin
                                    if (sum > MAX_VAL) begin
                                        state_d = ERR;
                                    end else begin
                                        value_d    = sum[W-1:0];
                                        neg_d      = 1'b0;
                                        fresh_d    = 1'b1;
                                        ret_b_d    = 1'b0;
                                        start_conv = 1'b1;
                                    end
                                end
                                OP_SUB: begin
                                    if (reg_a_q >= value_q) begin
                                        value_d = reg_a_q - value_q;
                                        neg_d   = 1'b0;
                                    end else begin
                                        value_d = value_q - reg_a_q;
                                        neg_d   = 1'b1;
                                    end
                                    fresh_d    = 1'b1;
                                    ret_b_d    = 1'b0;
                                    start_conv = 1'b1;
                                end
                                OP_MUL: begin
                                    state_d = MUL;
                                    prod_d  = '0;
                                    mcand_d = (2*W)'(reg_a_q);
                                end
                                default: begin
                                    if (value_q == '0) begin
                                        state_d = ERR;
                                    end else begin
                                        state_d = DIV;
                                        sh_d    = reg_a_q;
                                        rem_d   = '0;
                                    end
                                end
                            endcase
                        end
                    end else begin
                        // Operator keys: latch A in ENT_A, allow swapping the op before any B digit.
                        if (state_q == ENT_A) begin
                            if (neg_q) begin
                                state_d = ERR;
                            end else begin
                                reg_a_d    = value_q;
                                op_d       = cmd[1:0];
                                value_d    = '0;
                                count_d    = '0;
                                fresh_d    = 1'b0;
                                ret_b_d    = 1'b1;
                                start_conv = 1'b1;
                            end
                        end else if (count_q == '0) begin
                            op_d = cmd[1:0];
                        end else begin
                            state_d = ERR;
                        end
                    end
                end
            end
            MUL: begin
                prod_d  = prod_n;
                mcand_d = mcand_q << 1;
                reg_b_d = reg_b_q >> 1;
                cyc_d   = cyc_q + 1'b1;
                if (cyc_q == CNTW'(W - 1)) begin
                    if (prod_n > MAX_VAL) begin
                        state_d = ERR;
                    end else begin
                        value_d    = prod_n[W-1:0];
                        neg_d      = 1'b0;
                        fresh_d    = 1'b1;
                        ret_b_d    = 1'b0;
                        start_conv = 1'b1;
                    end
                end
            end
            DIV: begin
                rem_d = q_bit ? div_diff[W-1:0] : div_tmp[W-1:0];
                sh_d  = {sh_q[W-2:0], q_bit};
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CNTW'(W - 1)) begin
                    value_d    = {sh_q[W-2:0], q_bit};
                    neg_d      = 1'b0;
                    fresh_d    = 1'b1;
                    ret_b_d    = 1'b0;
                    start_conv = 1'b1;
                end
            end
            CONV: begin
                bcd_d = bcd_n;
                sh_d  = sh_q << 1;
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CNTW'(W - 1)) begin
                    state_d = SCAN;
                    scan_d  = '0;
                    count_d = sig_digits(bcd_n);
                end
            end
            SCAN: begin
                scan_d = scan_q + 1'b1;
                if (scan_q == PW'(NDIG - 1)) begin
                    state_d = ret_b_q ? ENT_B : ENT_A;
                    scan_d  = '0;
                end
            end
            default: begin
                state_d = ERR;
            end
        endcase

        if (start_conv) begin
            state_d = CONV;
            sh_d    = value_d;
            bcd_d   = '0;
            cyc_d   = '0;
        end
        if (state_d == ERR) begin
            value_d = '0;
            neg_d   = 1'b0;
        end
    end

    always_comb begin
        cmd_ready  = (state_q == ENT_A) || (state_q == ENT_B);
        data_valid = (state_q == SCAN);
        pos        = (state_q == SCAN) ? scan_q : '0;
        data       = (state_q == SCAN) ? bcd_q[4*scan_q +: 4] : 4'd0;
        value      = value_q;
        neg        = neg_q;
        case (state_q)
            ENT_A, ENT_B: status = 2'b10;
            ERR:          status = 2'b00;
            default:      status = 2'b01;
        endcase
    end

endmodule

// File: tb/tb_calc_bcd_n.sv
// Directed bench for calc_bcd_n: command sequences with hand-computed results,
// busy-window lengths and scanned BCD digits checked against an expected queue.
module tb_calc_bcd_n;

    localparam int NDIG = 8;
    localparam int W    = 27;
    localparam int PW   = $clog2(NDIG);

    localparam logic [3:0] K_ADD = 4'd10;
    localparam logic [3:0] K_SUB = 4'd11;
    localparam logic [3:0] K_MUL = 4'd12;
    localparam logic [3:0] K_DIV = 4'd13;
    localparam logic [3:0] K_EQ  = 4'd14;
    localparam logic [3:0] K_BS  = 4'd15;

    logic          clock;
    logic          reset_n;
    logic          cmd_valid;
    logic [3:0]    cmd;
    logic          cmd_ready;
    logic [1:0]    status;
    logic [W-1:0]  value;
    logic          neg;
    logic [3:0]    data;
    logic [PW-1:0] pos;
    logic          data_valid;

    int n_cmp;
    int n_bad;
    int lo;
    int busy_st;
    int cur;
    logic [7:0] exp_q[$];

    calc_bcd_n dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_ready  (cmd_ready),
        .status     (status),
        .value      (value),
        .neg        (neg),
        .data       (data),
        .pos        (pos),
        .data_valid (data_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        int r;
        r = 0;
        for (int i = 0; i < NDIG; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    task automatic expect_scan(input int word);
        for (int i = 0; i < NDIG; i++) exp_q.push_back({4'(i), 4'(word >> (4 * i))});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
        cur = 0;
    endtask

    task automatic send(input logic [3:0] c);
        @(negedge clock);
        cmd       = c;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    // Counts not-ready cycles after an accepted command and checks scanned digits.
    task automatic wait_ready(input int bound, output int cycles);
        cycles  = 0;
        busy_st = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (cmd_ready) break;
            if (busy_st < 0) busy_st = int'(status);
            cycles++;
            if (data_valid) begin
                if (exp_q.size() > 0) check("scan", {4'(pos), data}, exp_q.pop_front());
                else check("scan_extra", 1, 0);
            end
        end
        if (exp_q.size() > 0) begin
            check("scan_left", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // exp_val < 0 means the command must not refresh the display.
    task automatic do_cmd(input logic [3:0] c, input int exp_val);
        if (exp_val >= 0) expect_scan(to_bcd(exp_val));
        send(c);
        wait_ready(150, lo);
    endtask

    task automatic enter(input int n);
        int d[$];
        int t;
        t = n;
        if (t == 0) d.push_back(0);
        while (t > 0) begin
            d.push_front(t % 10);
            t = t / 10;
        end
        foreach (d[k]) begin
            t = cur * 10 + d[k];
            do_cmd(4'(d[k]), (t != cur) ? t : -1);
            cur = t;
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        cur       = 0;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 4'd0;
        #2;
        check("rst_status", status, 2'b10);
        check("rst_ready", cmd_ready, 1);
        check("rst_value", value, 0);
        check("rst_neg", neg, 0);
        check("rst_data", data, 0);
        check("rst_pos", pos, 0);
        check("rst_dvalid", data_valid, 0);
        do_reset();

        // 1,2,3 -> 123, then backspace -> 12
        expect_scan(32'h1);
        send(4'd1);
        wait_ready(150, lo);
        check("lat_d1", lo, 35);
        check("busy_status", busy_st, 1);
        check("val_1", value, 1);
        expect_scan(32'h12);
        send(4'd2);
        wait_ready(150, lo);
        check("lat_d2", lo, 35);
        expect_scan(32'h123);
        send(4'd3);
        wait_ready(150, lo);
        check("lat_d3", lo, 35);
        check("val_123", value, 123);
        do_cmd(K_BS, 12);
        check("val_bs", value, 12);
        check("lat_bs", lo, 35);

        // commands that leave value unchanged
        do_reset();
        do_cmd(K_BS, -1);
        check("bs0_lat", lo, 0);
        check("bs0_val", value, 0);
        do_cmd(4'd0, -1);
        check("zero_lat", lo, 0);
        do_cmd(K_EQ, -1);
        check("eqA_lat", lo, 0);

        // 12 + 30 = 42, chained + 8 = 50
        do_reset();
        enter(12);
        do_cmd(K_ADD, 0);
        cur = 0;
        enter(30);
        do_cmd(K_EQ, 42);
        check("add_val", value, 42);
        check("add_neg", neg, 0);
        do_cmd(K_ADD, 0);
        cur = 0;
        enter(8);
        do_cmd(K_EQ, 50);
        check("chain_val", value, 50);

        // 30 - 12 = 18
        do_reset();
        enter(30);
        do_cmd(K_SUB, 0);
        cur = 0;
        enter(12);
        do_cmd(K_EQ, 18);
        check("sub_val", value, 18);
        check("sub_neg", neg, 0);

        // 5 - 9 = -4, then op on negative -> error
        do_reset();
        enter(5);
        do_cmd(K_SUB, 0);
        cur = 0;
        enter(9);
        do_cmd(K_EQ, 4);
        check("subn_val", value, 4);
        check("subn_neg", neg, 1);
        send(K_ADD);
        wait_ready(20, lo);
        check("negop_status", status, 2'b00);
        check("negop_ready", cmd_ready, 0);
        check("negop_val", value, 0);
        check("negop_neg", neg, 0);

        // 250 * 4 = 1000
        do_reset();
        enter(250);
        do_cmd(K_MUL, 0);
        cur = 0;
        enter(4);
        do_cmd(K_EQ, 1000);
        check("mul_val", value, 1000);
        check("mul_lat", lo, 62);

        // nine 9s, then * 2 overflows
        do_reset();
        for (int i = 0; i < 8; i++) enter(9);
        check("nines_val", value, 99999999);
        do_cmd(4'd9, -1);
        check("ninth_lat", lo, 0);
        check("ninth_val", value, 99999999);
        do_cmd(K_MUL, 0);
        cur = 0;
        enter(2);
        send(K_EQ);
        wait_ready(100, lo);
        check("mulovf_status", status, 2'b00);
        check("mulovf_ready", cmd_ready, 0);
        check("mulovf_val", value, 0);
        check("mulovf_dvalid", data_valid, 0);

        // 100 / 7 = 14
        do_reset();
        enter(100);
        do_cmd(K_DIV, 0);
        cur = 0;
        enter(7);
        do_cmd(K_EQ, 14);
        check("div_val", value, 14);
        check("div_lat", lo, 62);

        // 5 / 0 -> error on the very next cycle
        do_reset();
        enter(5);
        do_cmd(K_DIV, 0);
        cur = 0;
        enter(0);
        send(K_EQ);
        @(negedge clock);
        check("div0_status", status, 2'b00);
        check("div0_ready", cmd_ready, 0);

        // reset asserted in the middle of a multiply
        do_reset();
        enter(250);
        do_cmd(K_MUL, 0);
        cur = 0;
        enter(4);
        send(K_EQ);
        repeat (10) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("midrst_status", status, 2'b10);
        check("midrst_ready", cmd_ready, 1);
        check("midrst_val", value, 0);
        check("midrst_dvalid", data_valid, 0);
        @(negedge clock);
        reset_n = 1'b1;
        cur = 0;
        @(negedge clock);
        check("post_status", status, 2'b10);
        enter(7);
        check("post_val", value, 7);
        check("post_lat", lo, 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
